// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Boot-time program writer for the pipeline's instruction memory. It parses a
//   byte stream holding a 16-bit word count (low byte first) and then that many
//   little-endian 32-bit words. Each word is written to consecutive imem word
//   addresses starting at BASE_ADDR. The core is held in reset until the whole
//   image is written.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   start      in   1-cycle pulse that restarts a load (honoured in DONE/ERR only)
//   in_data    in   stream byte
//   in_valid   in   in_data valid
//   in_ready   out  loader can accept a byte
//   imem_we    out  imem write strobe, one cycle per word
//   imem_addr  out  byte address of the write (word aligned)
//   imem_wdata out  instruction word
//   cpu_rst_n  out  active-low core reset, released only in DONE
//   done       out  image fully loaded
//   error      out  frame rejected (oversized count or inter-byte timeout)
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    MAX_WORDS  = 1024,
    parameter int                    TIMEOUT    = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_rst_n,
    output logic                  done,
    output logic                  error
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_CNT_LO,
        S_CNT_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_reg;
    logic [7:0]          lo_reg;     // low byte of the word count
    logic [15:0]         count_reg;  // N, the number of words in the frame
    logic [15:0]         idx_reg;    // index of the word currently being assembled
    logic [1:0]          cnt_reg;    // byte lane of the next data byte
    logic [23:0]         word_reg;   // first three bytes of the current word
    logic [IDLE_W-1:0]   idle_reg;   // cycles since the last accepted byte

    logic        xfer;
    logic [15:0] count_in;
    logic        idle_expired;

    // Gated by rst so the host never sees a ready loader while it is held in reset.
    assign in_ready = rst & ((state_reg == S_CNT_LO) ||
                             (state_reg == S_CNT_HI) ||
                             (state_reg == S_DATA));
    assign xfer         = in_valid & in_ready;
    assign count_in     = {in_data, lo_reg};
    // The idle count reaches TIMEOUT on this edge if it is already at TIMEOUT-1.
    assign idle_expired = (idle_reg == IDLE_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= S_CNT_LO;
            lo_reg     <= '0;
            count_reg  <= '0;
            idx_reg    <= '0;
            cnt_reg    <= '0;
            word_reg   <= '0;
            idle_reg   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst_n  <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state_reg)
                S_CNT_LO: begin
                    // Waiting for a frame to begin is unbounded: no idle counting.
                    if (xfer) begin
                        lo_reg    <= in_data;
                        idle_reg  <= '0;
                        state_reg <= S_CNT_HI;
                    end
                end

                S_CNT_HI: begin
                    if (xfer) begin
                        idle_reg  <= '0;
                        count_reg <= count_in;
                        idx_reg   <= '0;
                        cnt_reg   <= '0;
                        if (count_in == 16'd0) begin
                            state_reg <= S_DONE;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                        end else if (32'(count_in) > 32'(MAX_WORDS)) begin
                            state_reg <= S_ERR;
                            error     <= 1'b1;
                        end else begin
                            state_reg <= S_DATA;
                        end
                    end else if (idle_expired) begin
                        state_reg <= S_ERR;
                        error     <= 1'b1;
                    end else begin
                        idle_reg <= idle_reg + 1'b1;
                    end
                end

                S_DATA: begin
                    if (xfer) begin
                        idle_reg <= '0;
                        if (cnt_reg == 2'd3) begin
                            // Fourth byte completes the word; present it to imem next cycle.
                            imem_we    <= 1'b1;
                            imem_addr  <= BASE_ADDR + (ADDR_WIDTH'(idx_reg) << 2);
                            imem_wdata <= {in_data, word_reg};
                            cnt_reg    <= '0;
                            state_reg  <= S_WRITE;
                        end else begin
                            // Shift right: after three bytes the first one sits in lane 0.
                            word_reg <= {in_data, word_reg[23:8]};
                            cnt_reg  <= cnt_reg + 2'd1;
                        end
                    end else if (idle_expired) begin
                        state_reg <= S_ERR;
                        error     <= 1'b1;
                    end else begin
                        idle_reg <= idle_reg + 1'b1;
                    end
                end

                S_WRITE: begin
                    if ((17'(idx_reg) + 17'd1) == 17'(count_reg)) begin
                        state_reg <= S_DONE;
                        done      <= 1'b1;
                        cpu_rst_n <= 1'b1;
                    end else begin
                        idx_reg   <= idx_reg + 16'd1;
                        state_reg <= S_DATA;
                    end
                end

                S_DONE, S_ERR: begin
                    // imem_addr/imem_wdata keep the last write across a restart.
                    if (start) begin
                        state_reg <= S_CNT_LO;
                        idx_reg   <= '0;
                        cnt_reg   <= '0;
                        idle_reg  <= '0;
                        cpu_rst_n <= 1'b0;
                        done      <= 1'b0;
                        error     <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= S_CNT_LO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//   Directed bench for imem_loader. Stimulus pushes the expected imem writes
//   into a scoreboard queue; a monitor pops and compares on every imem_we.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst_n;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    imem_loader #(
        .ADDR_WIDTH (32),
        .BASE_ADDR  (32'h0),
        .MAX_WORDS  (1024),
        .TIMEOUT    (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .done       (done),
        .error      (error)
    );

    int          checks = 0;
    int          errors = 0;
    int          wr_count = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] mon_addr;
    logic [31:0] mon_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_count++;
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected no write",
                         imem_addr, imem_wdata);
            end else begin
                mon_addr = exp_addr_q.pop_front();
                mon_data = exp_data_q.pop_front();
                $display("write addr=0x%08h data=0x%08h (expected 0x%08h @ 0x%08h)",
                         imem_addr, imem_wdata, mon_data, mon_addr);
                check("write_addr", imem_addr, mon_addr);
                check("write_data", imem_wdata, mon_data);
            end
        end
    end

    // Called at a negedge; returns at the negedge right after the byte's transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_wait: in_ready stayed 0, required 1");
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 8'hA5;   // junk while idle; must be ignored
    endtask

    task automatic send_frame(input int n, input logic [31:0] w0, input logic [31:0] w1,
                              input bit stall);
        logic [15:0] nn;
        logic [31:0] w;
        nn = 16'(n);
        send_byte(nn[7:0],  stall ? 1 + int'($urandom_range(0, 3)) : 0);
        send_byte(nn[15:8], stall ? 1 + int'($urandom_range(0, 3)) : 0);
        for (int i = 0; i < n; i++) begin
            w = (i == 0) ? w0 : w1;
            exp_addr_q.push_back(32'(i) * 32'd4);
            exp_data_q.push_back(w);
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8], stall ? 1 + int'($urandom_range(0, 3)) : 0);
            end
        end
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd1);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_pending_writes"}, 32'(exp_addr_q.size()), 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check({tag, "_imem_we"},   32'(imem_we),   32'd0);
        check({tag, "_imem_addr"}, imem_addr,      32'd0);
        check({tag, "_imem_wdata"}, imem_wdata,    32'd0);
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_error"},     32'(error),     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_before;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        check("post_reset_cpu_rst_n", 32'(cpu_rst_n), 32'd0);

        // Two-word frame, no stalls
        wr_before = wr_count;
        send_frame(2, 32'h00100513, 32'h00200593, 1'b0);
        wait_done("t1");
        check("t1_write_count", 32'(wr_count - wr_before), 32'd2);
        check("t1_hold_addr", imem_addr, 32'h4);
        check("t1_hold_wdata", imem_wdata, 32'h00200593);
        check("t1_in_ready_done", 32'(in_ready), 32'd0);

        // Same frame with in_valid toggling and random stalls
        pulse_start();
        check("t2_restart_done", 32'(done), 32'd0);
        check("t2_restart_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        wr_before = wr_count;
        send_frame(2, 32'h00100513, 32'h00200593, 1'b1);
        wait_done("t2");
        check("t2_write_count", 32'(wr_count - wr_before), 32'd2);

        // Zero-length image: done one cycle after the count high byte
        pulse_start();
        wr_before = wr_count;
        send_byte(8'h00, 0);
        check("t3_done_after_lo", 32'(done), 32'd0);
        send_byte(8'h00, 0);
        check("t3_done", 32'(done), 32'd1);
        check("t3_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        check("t3_write_count", 32'(wr_count - wr_before), 32'd0);

        // Oversized count 0x0401 > 1024, then recovery with start
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        check("t4_error", 32'(error), 32'd1);
        check("t4_in_ready", 32'(in_ready), 32'd0);
        check("t4_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("t4_done", 32'(done), 32'd0);
        pulse_start();
        check("t4_error_cleared", 32'(error), 32'd0);
        check("t4_in_ready_restart", 32'(in_ready), 32'd1);
        wr_before = wr_count;
        send_frame(1, 32'hDEADBEEF, 32'h0, 1'b0);
        wait_done("t4");
        check("t4_write_count", 32'(wr_count - wr_before), 32'd1);

        // Timeout: 15 idle cycles tolerated, the 16th errors out
        pulse_start();
        wr_before = wr_count;
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        repeat (15) @(negedge clk);
        check("t5_error_at_15", 32'(error), 32'd0);
        @(negedge clk);
        check("t5_error_at_16", 32'(error), 32'd1);
        check("t5_in_ready", 32'(in_ready), 32'd0);
        check("t5_write_count", 32'(wr_count - wr_before), 32'd0);

        // Reset mid-frame, then a fresh frame
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h77, 0);
        send_byte(8'h66, 0);
        send_byte(8'h55, 0);
        rst = 1'b0;
        #1;
        check_reset_outputs("t6_in_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        wr_before = wr_count;
        send_frame(2, 32'hAABBCCDD, 32'h11223344, 1'b0);
        wait_done("t6");
        check("t6_write_count", 32'(wr_count - wr_before), 32'd2);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
